wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 117 +++++++++++
 tb/tb_wb_regfile.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 x 32-bit GPRs with combinational read ports,
// write-through bypass, load-data extraction/extension and a retired-instruction counter.
// Ports: clock/reset (sync, active-low); wb_* writeback controls and data in;
// rs/rt read address in, read data out; wb_data/wb_we selected writeback value and
// effective enable out; retired 32-bit count of non-NOP, non-squashed instructions out.
// Write latency 1 cycle; read ports and wb_data are combinational.
module wb_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_mem_to_reg,
  input  logic        wb_pc_to_reg,
  input  logic        wb_reg_write,
  input  logic        wb_hazard,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_ir,
  input  logic [31:0] wb_alu_res,
  input  logic [31:0] wb_mem_data,
  input  logic [4:0]  wb_write_addr,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic [31:0] retired
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic [31:0] regs_q [32];
  logic [31:0] retired_q;
  logic [31:0] retired_d;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Big-endian lanes: byte offset 0 is the most significant byte of the word.
  always_comb begin
    ld_byte = wb_mem_data[31:24];
    case (wb_alu_res[1:0])
      2'd0: ld_byte = wb_mem_data[31:24];
      2'd1: ld_byte = wb_mem_data[23:16];
      2'd2: ld_byte = wb_mem_data[15:8];
      2'd3: ld_byte = wb_mem_data[7:0];
      default: ld_byte = wb_mem_data[31:24];
    endcase
    ld_half = wb_alu_res[1] ? wb_mem_data[15:0] : wb_mem_data[31:16];
  end

  // Anything that is not a sub-word load passes the whole word (lw and the rest).
  always_comb begin
    ld_data = wb_mem_data;
    case (wb_ir[31:26])
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = wb_mem_data;
    endcase
  end

  always_comb begin
    wb_data = wb_alu_res;
    if (wb_pc_to_reg) begin
      wb_data = wb_pc + 32'd8;
    end else if (wb_mem_to_reg) begin
      wb_data = ld_data;
    end
  end

  // Gating with reset keeps bypass off while reset is held, so reads show stored state.
  assign wb_we = wb_reg_write & ~wb_hazard & (wb_write_addr != 5'd0) & reset;

  always_comb begin
    rs_data = (rs_addr == 5'd0) ? 32'd0 : regs_q[rs_addr];
    if (wb_we && (rs_addr == wb_write_addr)) begin
      rs_data = wb_data;
    end
    rt_data = (rt_addr == 5'd0) ? 32'd0 : regs_q[rt_addr];
    if (wb_we && (rt_addr == wb_write_addr)) begin
      rt_data = wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wb_we) begin
      regs_q[wb_write_addr] <= wb_data;
    end
  end

  // Counts every real instruction reaching writeback, stores or not; wraps silently.
  always_comb begin
    retired_d = retired_q;
    if ((wb_ir != 32'd0) && !wb_hazard) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a reference model predicts every output for each driven cycle,
// expectations are queued at drive time and popped against DUT outputs before the edge.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic        wb_mem_to_reg;
  logic        wb_pc_to_reg;
  logic        wb_reg_write;
  logic        wb_hazard;
  logic [31:0] wb_pc;
  logic [31:0] wb_ir;
  logic [31:0] wb_alu_res;
  logic [31:0] wb_mem_data;
  logic [4:0]  wb_write_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] retired;

  wb_regfile dut (
    .clock         (clock),
    .reset         (reset),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_pc_to_reg  (wb_pc_to_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_hazard     (wb_hazard),
    .wb_pc         (wb_pc),
    .wb_ir         (wb_ir),
    .wb_alu_res    (wb_alu_res),
    .wb_mem_data   (wb_mem_data),
    .wb_write_addr (wb_write_addr),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_data       (wb_data),
    .wb_we         (wb_we),
    .retired       (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_ret;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  localparam logic [31:0] IR_ADD = 32'h0085_2820;
  localparam logic [31:0] IR_LB  = 32'h8000_0000;
  localparam logic [31:0] IR_LH  = 32'h8400_0000;
  localparam logic [31:0] IR_LW  = 32'h8C00_0000;
  localparam logic [31:0] IR_LBU = 32'h9000_0000;
  localparam logic [31:0] IR_LHU = 32'h9400_0000;
  localparam logic [31:0] IR_JAL = 32'h0C00_0004;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] ir, input logic [31:0] ea,
                                             input logic [31:0] mem);
    logic [31:0] b;
    logic [31:0] h;
    b = (mem >> (8 * (3 - ea[1:0]))) & 32'hFF;
    h = ea[1] ? (mem & 32'hFFFF) : (mem >> 16);
    case (ir[31:26])
      6'h20:   return (b[7]  ? 32'hFFFF_FF00 : 32'h0) | b;
      6'h24:   return b;
      6'h21:   return (h[15] ? 32'hFFFF_0000 : 32'h0) | h;
      6'h25:   return h;
      default: return mem;
    endcase
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  // One cycle: drive at negedge, predict, compare before the edge, advance the model.
  task automatic cycle(input string name, input logic rst, input logic m2r, input logic p2r,
                       input logic rw, input logic hz, input logic [31:0] pc,
                       input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] wa, input logic [4:0] ra, input logic [4:0] rb);
    logic [31:0] e_wb;
    logic        e_we;
    logic [31:0] e_a;
    logic [31:0] e_b;
    reset = rst; wb_mem_to_reg = m2r; wb_pc_to_reg = p2r; wb_reg_write = rw;
    wb_hazard = hz; wb_pc = pc; wb_ir = ir; wb_alu_res = alu; wb_mem_data = mem;
    wb_write_addr = wa; rs_addr = ra; rt_addr = rb;

    if (p2r)      e_wb = pc + 32'd8;
    else if (m2r) e_wb = model_load(ir, alu, mem);
    else          e_wb = alu;
    e_we = rst && rw && !hz && (wa != 0);
    e_a  = (e_we && ra == wa) ? e_wb : m_regs[ra];
    e_b  = (e_we && rb == wa) ? e_wb : m_regs[rb];
    push({name, ".wb_data"}, e_wb);
    push({name, ".wb_we"},   {31'd0, e_we});
    push({name, ".rs_data"}, e_a);
    push({name, ".rt_data"}, e_b);
    push({name, ".retired"}, m_ret);

    #1;
    check(tag_q.pop_front(), wb_data,        exp_q.pop_front());
    check(tag_q.pop_front(), {31'd0, wb_we}, exp_q.pop_front());
    check(tag_q.pop_front(), rs_data,        exp_q.pop_front());
    check(tag_q.pop_front(), rt_data,        exp_q.pop_front());
    check(tag_q.pop_front(), retired,        exp_q.pop_front());

    @(posedge clock);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_ret = 32'd0;
    end else begin
      if (e_we) m_regs[wa] = e_wb;
      if (ir != 0 && !hz) m_ret = m_ret + 32'd1;
    end
    @(negedge clock);
  endtask

  task automatic idle(input string name, input logic [4:0] ra, input logic [4:0] rb);
    cycle(name, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, ra, rb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
    m_ret = 32'hX;
    @(negedge clock);

    // Reset with a write and a valid instruction pending: reset wins.
    cycle("rst0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, IR_ADD, 32'h1111_1111, 32'h0,
          5'd3, 5'd3, 5'd4);
    cycle("rst1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, IR_ADD, 32'h2222_2222, 32'h0,
          5'd3, 5'd3, 5'd0);

    // First edge out of reset: write must land.
    cycle("w5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, IR_ADD, 32'hDEAD_BEEF, 32'h0,
          5'd5, 5'd5, 5'd5);
    idle("r5", 5'd5, 5'd0);

    // Loads into r8..r14.
    cycle("lb1",  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, IR_LB,  32'h1000_0001, 32'h12F4_5678,
          5'd8, 5'd8, 5'd5);
    cycle("lbu1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, IR_LBU, 32'h1000_0001, 32'h12F4_5678,
          5'd9, 5'd8, 5'd9);
    cycle("lh2",  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, IR_LH,  32'h1000_0002, 32'h12F4_5678,
          5'd10, 5'd10, 5'd9);
    cycle("lh0",  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, IR_LH,  32'h1000_0000, 32'h8001_7FFF,
          5'd11, 5'd11, 5'd10);
    cycle("lhu0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, IR_LHU, 32'h1000_0000, 32'h8001_7FFF,
          5'd12, 5'd12, 5'd12);
    cycle("lb3",  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, IR_LB,  32'h1000_0003, 32'h0000_00F0,
          5'd13, 5'd13, 5'd11);
    cycle("lw",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, IR_LW,  32'h1000_0003, 32'hCAFE_F00D,
          5'd14, 5'd14, 5'd13);

    // Link address wins over the load path.
    cycle("jal", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0040_0010, IR_JAL, 32'h1000_0000,
          32'h1234_5678, 5'd31, 5'd31, 5'd14);
    idle("r31", 5'd31, 5'd8);

    // r0 is never written; squashed write to r7 changes nothing, including retired.
    cycle("r0w", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, IR_ADD, 32'hFFFF_FFFF, 32'h0,
          5'd0, 5'd0, 5'd0);
    cycle("hz7", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, IR_ADD, 32'h7777_7777, 32'h0,
          5'd7, 5'd7, 5'd7);
    idle("r7", 5'd7, 5'd0);
    // Non-writing valid instruction still counts.
    cycle("nowr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, IR_ADD, 32'h5555_5555, 32'h0,
          5'd6, 5'd6, 5'd5);

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      cycle("rnd", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
            $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFF),
            $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end

    // Counter wrap: pin the counter to all-ones across one idle edge, then release.
    force dut.retired_q = 32'hFFFF_FFFF;
    m_ret = 32'hFFFF_FFFF;
    idle("pre", 5'd0, 5'd0);
    release dut.retired_q;
    cycle("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, IR_ADD, 32'h0, 32'h0,
          5'd0, 5'd0, 5'd0);
    idle("wrapped", 5'd0, 5'd0);

    // Mid-stream reset with a write to r3 and a valid instruction on the same edge.
    cycle("w3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, IR_ADD, 32'h3333_3333, 32'h0,
          5'd3, 5'd3, 5'd5);
    cycle("rst3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, IR_ADD, 32'h4444_4444, 32'h0,
          5'd3, 5'd3, 5'd5);
    for (int i = 0; i < 32; i++) begin
      idle("clr", 5'(i), 5'(31 - i));
    end

    if (exp_q.size() != 0) check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
